// File: rtl/tcdm_burst_reader_pkg.sv
// Shared types and TCDM constants for the burst reader.
// Imported by the reader top and its response FIFO.
package tcdm_burst_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  localparam logic        TCDM_WEN_READ = 1'b1;
  localparam logic [3:0]  TCDM_BE_FULL  = 4'hF;
  localparam logic [31:0] TCDM_WDATA_RD = 32'h0;
  localparam logic [31:0] WORD_STRIDE   = 32'd4;
  localparam logic [31:0] WORD_MASK     = 32'hFFFF_FFFC;

endpackage

// File: rtl/tcdm_resp_fifo.sv
// Response buffer for the burst reader.
// Push and pop may coincide at any occupancy.
module tcdm_resp_fifo
  import tcdm_burst_reader_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        empty,
  output logic        full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [31:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Extra pointer bit separates full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '{default: '0};
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/tcdm_burst_reader.sv
// TCDM burst reader: issues word reads under a credit
// limit and streams the in-order responses out.
module tcdm_burst_reader
  import tcdm_burst_reader_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [31:0]          start_addr_i,
  input  logic [CNT_WIDTH-1:0] num_words_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 tcdm_req_o,
  output logic [31:0]          tcdm_add_o,
  output logic                 tcdm_wen_o,
  output logic [31:0]          tcdm_wdata_o,
  output logic [3:0]           tcdm_be_o,
  input  logic                 tcdm_gnt_i,
  input  logic                 tcdm_r_valid_i,
  input  logic [31:0]          tcdm_r_rdata_i,
  input  logic                 tcdm_r_opc_i,
  output logic [31:0]          data_o,
  output logic                 valid_o,
  input  logic                 ready_i
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CREDITS = FIFO_DEPTH[CW:0];
  localparam logic [CW-1:0] C_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] N_ONE =
    {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  rd_state_e            state_q;
  logic [31:0]          addr_q;
  logic [CNT_WIDTH-1:0] rem_q;
  logic [CW-1:0]        infl_q;
  logic [CW-1:0]        occ_q;
  logic                 done_q;
  logic                 err_q;

  logic        hs;
  logic        resp;
  logic        pop;
  logic        fifo_empty;
  logic        fifo_full;
  logic [CW:0] used;

  // Outstanding reads plus buffered words never exceed the FIFO.
  assign used = {1'b0, infl_q} + {1'b0, occ_q};

  assign tcdm_req_o = (state_q == ST_ISSUE) &&
                      (used < CREDITS) && !fifo_full;
  assign hs   = tcdm_req_o & tcdm_gnt_i;
  // Stale responses from before a reset land while idle.
  assign resp = tcdm_r_valid_i & (state_q != ST_IDLE);

  assign valid_o = ~fifo_empty;
  assign pop     = valid_o & ready_i;

  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign tcdm_add_o   = addr_q;
  assign tcdm_wen_o   = TCDM_WEN_READ;
  assign tcdm_wdata_o = TCDM_WDATA_RD;
  assign tcdm_be_o    = TCDM_BE_FULL;

  tcdm_resp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (resp),
    .pop   (pop),
    .din   (tcdm_r_rdata_i),
    .dout  (data_o),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      infl_q  <= '0;
      occ_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;

      case ({hs, resp})
        2'b10:   infl_q <= infl_q + C_ONE;
        2'b01:   infl_q <= infl_q - C_ONE;
        default: infl_q <= infl_q;
      endcase

      case ({resp, pop})
        2'b10:   occ_q <= occ_q + C_ONE;
        2'b01:   occ_q <= occ_q - C_ONE;
        default: occ_q <= occ_q;
      endcase

      if (resp && tcdm_r_opc_i) begin
        err_q <= 1'b1;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            err_q <= 1'b0;
            if (num_words_i != '0) begin
              state_q <= ST_ISSUE;
              addr_q  <= start_addr_i & WORD_MASK;
              rem_q   <= num_words_i;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (hs) begin
            addr_q <= addr_q + WORD_STRIDE;
            rem_q  <= rem_q - N_ONE;
            if (rem_q == N_ONE) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (infl_q == '0 && fifo_empty) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcdm_burst_reader.sv
// Bench for tcdm_burst_reader: TCDM slave and stream sink
// models with a queue-based reference of the burst.
module tb_tcdm_burst_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] start_addr;
  logic [15:0] num_words;
  logic        busy;
  logic        done;
  logic        err;
  logic        req;
  logic [31:0] add;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        gnt;
  logic        r_valid;
  logic [31:0] r_rdata;
  logic        r_opc;
  logic [31:0] data;
  logic        valid;
  logic        ready;

  typedef struct {
    logic [31:0] addr;
    int          due;
    logic        opc;
  } rsp_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  rsp_t        pend[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];

  int grants;
  int words;
  int dones;
  int first_grant;
  int last_grant;
  int first_valid;
  int start_cyc;
  int lat        = 1;
  int err_idx    = -1;
  int ready_mode = 0;
  int stall      = 0;
  bit gnt_rand   = 0;
  bit hold_pend  = 0;
  bit prev_opc   = 0;
  bit model_err  = 0;
  logic [31:0] hold_addr;

  tcdm_burst_reader #(
    .FIFO_DEPTH (4),
    .CNT_WIDTH  (16)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .start_addr_i   (start_addr),
    .num_words_i    (num_words),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err),
    .tcdm_req_o     (req),
    .tcdm_add_o     (add),
    .tcdm_wen_o     (wen),
    .tcdm_wdata_o   (wdata),
    .tcdm_be_o      (be),
    .tcdm_gnt_i     (gnt),
    .tcdm_r_valid_i (r_valid),
    .tcdm_r_rdata_i (r_rdata),
    .tcdm_r_opc_i   (r_opc),
    .data_o         (data),
    .valid_o        (valid),
    .ready_i        (ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_9617 ^ {a[31:16], 16'h0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of slave, sink and error model, at the falling edge.
  task automatic step();
    bit   started;
    bit   was_hold;
    rsp_t r;
    started = start;
    @(negedge clk);
    cyc++;
    if (started) model_err = 0;
    if (prev_opc) model_err = 1;
    chk("err_o", 32'(err), 32'(model_err));

    r_valid  = 1'b0;
    r_rdata  = 32'h0;
    r_opc    = 1'b0;
    prev_opc = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      r_valid  = 1'b1;
      r_rdata  = mem_f(r.addr);
      r_opc    = r.opc;
      prev_opc = r.opc;
    end

    was_hold  = hold_pend;
    hold_pend = 0;
    if (was_hold) begin
      chk("hold_req", 32'(req), 32'd1);
      chk("hold_add", add, hold_addr);
    end
    if (req) begin
      if (!was_hold) stall = gnt_rand ? int'($urandom_range(0, 3)) : 0;
      if (stall == 0) begin
        gnt = 1'b1;
        if (exp_addr.size() == 0) chk("extra_req", 32'(req), 32'd0);
        else chk("req_add", add, exp_addr.pop_front());
        pend.push_back('{addr: add, due: cyc + lat,
                         opc: (grants == err_idx)});
        if (grants == 0) first_grant = cyc;
        last_grant = cyc;
        grants++;
      end else begin
        gnt = 1'b0;
        stall--;
        hold_pend = 1;
        hold_addr = add;
      end
    end else begin
      gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    case (ready_mode)
      0:       ready = 1'b1;
      1:       ready = 1'b0;
      default: ready = 1'($urandom_range(0, 1));
    endcase
    if (valid && ready) begin
      if (words == 0) first_valid = cyc;
      if (exp_data.size() == 0) chk("extra_pop", 32'(valid), 32'd0);
      else chk("data_o", data, exp_data.pop_front());
      words++;
    end
    if (done) dones++;
  endtask

  task automatic start_burst(input logic [31:0] a, input int n,
                             input int e);
    logic [31:0] b;
    b = a & 32'hFFFF_FFFC;
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(b + 32'(4 * i));
      exp_data.push_back(mem_f(b + 32'(4 * i)));
    end
    err_idx     = e;
    grants      = 0;
    words       = 0;
    dones       = 0;
    first_valid = -1;
    first_grant = -1;
    last_grant  = -1;
    start_addr  = a;
    num_words   = 16'(n);
    start       = 1'b1;
    step();
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic finish_burst(input int n, input bit exp_err,
                              input int budget);
    int k;
    k = 0;
    while (dones == 0 && k < budget) begin
      step();
      k++;
    end
    chk("done_seen", 32'(dones), 32'd1);
    step();
    step();
    chk("done_once", 32'(dones), 32'd1);
    chk("words", 32'(words), 32'(n));
    chk("grants", 32'(grants), 32'(n));
    chk("busy_idle", 32'(busy), 32'd0);
    chk("err_final", 32'(err), 32'(exp_err));
  endtask

  initial begin
    logic [31:0] ra;
    int rn;
    int re;
    rst = 1'b1;
    start = 1'b0;
    start_addr = 32'h0;
    num_words = 16'h0;
    gnt = 1'b0;
    r_valid = 1'b0;
    r_rdata = 32'h0;
    r_opc = 1'b0;
    ready = 1'b0;
    #13;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_add", add, 32'd0);
    chk("rst_wen", 32'(wen), 32'd1);
    chk("rst_be", 32'(be), 32'hF);
    @(negedge clk);
    rst = 1'b0;

    // Full-rate burst: 1-cycle latency, gnt and ready high.
    start_burst(32'h1A00_0000, 8, -1);
    finish_burst(8, 1'b0, 100);
    chk("first_grant_lat", 32'(first_grant - start_cyc), 32'd0);
    chk("grant_span", 32'(last_grant - first_grant), 32'd7);
    chk("first_valid_lat", 32'(first_valid - start_cyc), 32'd2);
    chk("wen", 32'(wen), 32'd1);
    chk("be", 32'(be), 32'hF);
    chk("wdata", wdata, 32'd0);

    // Back-pressure: credits run out after FIFO_DEPTH grants.
    ready_mode = 1;
    start_burst(32'h0000_1002, 10, -1);
    repeat (12) step();
    chk("bp_grants", 32'(grants), 32'd4);
    chk("bp_req", 32'(req), 32'd0);
    chk("bp_valid", 32'(valid), 32'd1);
    ready_mode = 0;
    finish_burst(10, 1'b0, 200);

    // Grant stalls with random ready.
    gnt_rand = 1;
    ready_mode = 2;
    lat = 2;
    start_burst(32'h2000_0104, 12, -1);
    finish_burst(12, 1'b0, 400);

    // Address wrap.
    gnt_rand = 0;
    ready_mode = 0;
    lat = 1;
    start_burst(32'hFFFF_FFF8, 4, -1);
    finish_burst(4, 1'b0, 100);

    // Error on word 3 of 5, cleared by the next start.
    start_burst(32'h3000_0000, 5, 2);
    finish_burst(5, 1'b1, 100);
    start_burst(32'h3000_0100, 1, -1);
    finish_burst(1, 1'b0, 100);

    // Reset with two reads in flight.
    lat = 3;
    start_burst(32'h4000_0000, 8, -1);
    step();
    chk("pre_rst_grants", 32'(grants), 32'd2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req", 32'(req), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_data", data, 32'd0);
    chk("arst_add", add, 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_wen", 32'(wen), 32'd1);
    chk("arst_be", 32'(be), 32'hF);
    exp_addr.delete();
    exp_data.delete();
    model_err = 0;
    prev_opc = 0;
    hold_pend = 0;
    grants = 0;
    words = 0;
    dones = 0;
    step();
    rst = 1'b0;
    repeat (4) step();
    chk("no_stray", 32'(valid), 32'd0);
    chk("stale_busy", 32'(busy), 32'd0);
    lat = 1;
    start_burst(32'h5000_0000, 0, -1);
    chk("zero_done", 32'(done), 32'd1);
    finish_burst(0, 1'b0, 10);

    // Randomised bursts.
    for (int t = 0; t < 6; t++) begin
      ra = $urandom;
      rn = int'($urandom_range(1, 12));
      re = int'($urandom_range(0, 15));
      lat = int'($urandom_range(1, 3));
      gnt_rand = 1;
      ready_mode = 2;
      start_burst(ra, rn, re);
      finish_burst(rn, re < rn, 500);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
